// File: rtl/dir_lut_pipe.sv
// dir_lut_pipe: two-stage valid/ready pipeline mapping address bins to signed direction offsets.
// Define DIR_LUT_SAT_EN to saturate results and expose the per-lane out_sat port.
module dir_lut_pipe #(
  parameter int ADDR_W    = 8,
  parameter int OUT_W     = 5,
  parameter int BIN_SHIFT = 4,
  parameter int BASE      = 8,
  parameter int DESC      = 1,
  parameter int CH        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*ADDR_W-1:0]   a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*OUT_W-1:0]    spo
`ifdef DIR_LUT_SAT_EN
  ,
  output logic [CH-1:0]          out_sat
`endif
);
  localparam int VW = (ADDR_W > OUT_W ? ADDR_W : OUT_W) + 2;
  logic                 r_s1_v, r_s2_v;
  logic [CH*ADDR_W-1:0] r_idx, w_idx;
  logic [CH*OUT_W-1:0]  r_spo, w_spo;
  logic                 w_s1_en, w_s2_en;
`ifdef DIR_LUT_SAT_EN
  localparam logic signed [VW-1:0] MAXV = VW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [VW-1:0] MINV = VW'(-(2 ** (OUT_W - 1)));
  logic signed [VW-1:0] w_val;
  logic [CH-1:0]        r_sat, w_sat;
`endif
  assign w_s2_en   = !r_s2_v || out_ready;
  assign w_s1_en   = !r_s1_v || w_s2_en;
  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_v;
  assign spo       = r_spo;
`ifdef DIR_LUT_SAT_EN
  assign out_sat   = r_sat;
`endif
  always_comb begin
    w_idx = '0;
    w_spo = '0;
`ifdef DIR_LUT_SAT_EN
    w_sat = '0;
    w_val = '0;
`endif
    for (int k = 0; k < CH; k++) begin
      w_idx[k*ADDR_W +: ADDR_W] = a[k*ADDR_W +: ADDR_W] >> BIN_SHIFT;
`ifdef DIR_LUT_SAT_EN
      w_val = DESC != 0 ? VW'(BASE) - VW'(r_idx[k*ADDR_W +: ADDR_W])
                        : VW'(BASE) + VW'(r_idx[k*ADDR_W +: ADDR_W]);
      w_sat[k] = (w_val > MAXV) || (w_val < MINV);
      w_spo[k*OUT_W +: OUT_W] = w_val > MAXV ? MAXV[OUT_W-1:0] :
                                w_val < MINV ? MINV[OUT_W-1:0] : w_val[OUT_W-1:0];
`else
      w_spo[k*OUT_W +: OUT_W] = DESC != 0 ? OUT_W'(VW'(BASE) - VW'(r_idx[k*ADDR_W +: ADDR_W]))
                                          : OUT_W'(VW'(BASE) + VW'(r_idx[k*ADDR_W +: ADDR_W]));
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_idx  <= '0;
      r_spo  <= '0;
`ifdef DIR_LUT_SAT_EN
      r_sat  <= '0;
`endif
    end else begin
      if (w_s1_en) r_s1_v <= in_valid;
      if (w_s1_en && in_valid) r_idx <= w_idx;
      if (w_s2_en) r_s2_v <= r_s1_v;
      if (w_s2_en && r_s1_v) begin
        r_spo <= w_spo;
`ifdef DIR_LUT_SAT_EN
        r_sat <= w_sat;
`endif
      end
    end
  end
endmodule
